// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 signed shift-add multiplier.
package mult_pkg;

    localparam int WIDTH    = 8;
    localparam int LAST_BIT = WIDTH - 1;
    localparam int CNT_W    = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/mult_shift_reg.sv
// X/A/B product chain: load B, clear or load {X,A}, arithmetic right shift of {X,A,B}.
module mult_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_b,
    input  logic         clear_ax,
    input  logic         load_ax,
    input  logic         shift,
    input  logic [W-1:0] s,
    input  logic [W-1:0] sum,
    input  logic         sum_x,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         x
);

    always_ff @(posedge clk) begin
        if (reset) begin
            a <= '0;
            b <= '0;
            x <= 1'b0;
        end else begin
            if (load_b) begin
                b <= s;
            end
            if (clear_ax) begin
                a <= '0;
                x <= 1'b0;
            end else if (load_ax) begin
                a <= sum;
                x <= sum_x;
            end else if (shift) begin
                // X replicates into A's MSB, so the shift is arithmetic and X is kept.
                a <= {x, a[W-1:1]};
                b <= {a[0], b[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM and registers of the shift-add signed multiplier; the adder is external.
// Optional MULT_ADD_SKIP_EN: jump straight between SHIFT cycles when the next multiplier bit is 0.
module mult_seq_ctrl
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH:0]   Add_A9,
    output logic [WIDTH:0]   Add_B9,
    output logic             Add_Cin,
    input  logic [WIDTH-1:0] Add_Sum,
    input  logic             Add_X,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_BIT);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] a, b;
    logic             x;
    logic [CNT_W-1:0] count;
    logic             last_bit;
    logic             load_b, clear_ax, load_ax, shift, load_m, sub;
    logic [WIDTH:0]   m9;

    assign last_bit = (count == LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            m     <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (load_m) begin
                m     <= S;
                count <= '0;
            end else if (shift && !last_bit) begin
                count <= count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_b    = 1'b0;
        clear_ax  = 1'b0;
        load_ax   = 1'b0;
        shift     = 1'b0;
        load_m    = 1'b0;
        sub       = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (ClearA_LoadB) begin
                    load_b   = 1'b1;
                    clear_ax = 1'b1;
                end else if (Run) begin
                    state_nxt = START;
                end
            end
            START: begin
                load_m   = 1'b1;
                clear_ax = 1'b1;
`ifdef MULT_ADD_SKIP_EN
                state_nxt = b[0] ? ADD : SHIFT;
`else
                state_nxt = ADD;
`endif
            end
            ADD: begin
                // The sign bit of a two's complement multiplier has weight -2^(W-1).
                load_ax   = b[0];
                sub       = b[0] && last_bit;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end else begin
`ifdef MULT_ADD_SKIP_EN
                    state_nxt = b[1] ? ADD : SHIFT;
`else
                    state_nxt = ADD;
`endif
                end
            end
            DONE: begin
                Done = 1'b1;
                if (ClearA_LoadB) begin
                    load_b   = 1'b1;
                    clear_ax = 1'b1;
                end
                if (!Run) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    mult_shift_reg #(.W(WIDTH)) u_shift_reg (
        .clk      (Clk),
        .reset    (Reset),
        .load_b   (load_b),
        .clear_ax (clear_ax),
        .load_ax  (load_ax),
        .shift    (shift),
        .s        (S),
        .sum      (Add_Sum),
        .sum_x    (Add_X),
        .a        (a),
        .b        (b),
        .x        (x)
    );

    assign m9      = {m[WIDTH-1], m};
    assign Add_A9  = {a[WIDTH-1], a};
    assign Add_B9  = sub ? ~m9 : m9;
    assign Add_Cin = sub;
    assign Aval    = a;
    assign Bval    = b;
    assign Xval    = x;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with a behavioural 9-bit adder and a result scoreboard.
module tb_mult_seq_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, Run, ClearA_LoadB;
    logic [7:0] S;
    logic [8:0] Add_A9, Add_B9;
    logic       Add_Cin;
    logic [7:0] Add_Sum;
    logic       Add_X;
    logic [7:0] Aval, Bval;
    logic       Xval, Done;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    assign {Add_X, Add_Sum} = Add_A9 + Add_B9 + {8'd0, Add_Cin};

    mult_seq_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .Add_A9       (Add_A9),
        .Add_B9       (Add_B9),
        .Add_Cin      (Add_Cin),
        .Add_Sum      (Add_Sum),
        .Add_X        (Add_X),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Done         (Done)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       x;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] mplier;
        logic [7:0] mcand;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ex;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] mplier);
`ifdef MULT_ADD_SKIP_EN
        return 9 + $countones(mplier);
`else
        return 17 + 0 * int'(mplier[0]);
`endif
    endfunction

    task automatic push_exp(input logic [7:0] mplier, input logic [7:0] ea,
                            input logic [7:0] eb, input logic ex);
        exp_t e;
        e.a   = ea;
        e.b   = eb;
        e.x   = ex;
        e.lat = exp_lat(mplier);
        sb.push_back(e);
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic load_b(input logic [7:0] v);
        ClearA_LoadB = 1'b1;
        Run          = 1'b0;
        S            = v;
        @(posedge Clk);
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        chk("load_b", {Aval, Bval}, {8'h00, v});
    endtask

    // Run is sampled at the first posedge (t0); edges are counted from there.
    task automatic run_wait(input logic [7:0] mcand);
        int   n;
        bit   seen;
        exp_t e;
        Run  = 1'b1;
        S    = mcand;
        @(posedge Clk);
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (n == 1) S = 8'($urandom);
            if (Done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", n, e.lat);
            chk("product", {Xval, Aval, Bval}, {e.x, e.a, e.b});
        end else begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end
    endtask

    task automatic finish_run();
        Run = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("done_low_idle", 32'(Done), 32'd0);
    endtask

    initial begin
        logic signed [15:0] p;
        logic [7:0]         mp, mc;

        vecs[0] = '{8'h3B, 8'h07, 8'h01, 8'h9D, 1'b0};
        vecs[1] = '{8'h3B, 8'hF9, 8'hFE, 8'h63, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 8'h40, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'h55, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0};
        vecs[5] = '{8'h7F, 8'h80, 8'hC0, 8'h80, 1'b1};
        vecs[6] = '{8'h80, 8'h7F, 8'hC0, 8'h80, 1'b1};
        vecs[7] = '{8'h01, 8'h80, 8'hFF, 8'h80, 1'b1};

        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        S            = 8'h00;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        chk("reset_regs", {Done, Xval, Aval, Bval}, 32'd0);
        chk("reset_cin", 32'(Add_Cin), 32'd0);

        for (int i = 0; i < 8; i++) begin
            load_b(vecs[i].mplier);
            push_exp(vecs[i].mplier, vecs[i].ea, vecs[i].eb, vecs[i].ex);
            run_wait(vecs[i].mcand);
            finish_run();
        end

        for (int i = 0; i < 6; i++) begin
            mp = 8'($urandom);
            mc = 8'($urandom);
            p  = $signed({{8{mp[7]}}, mp}) * $signed({{8{mc[7]}}, mc});
            load_b(mp);
            push_exp(mp, p[15:8], p[7:0], p[15]);
            run_wait(mc);
            finish_run();
        end

        // Run held through DONE: no restart, registers stable.
        load_b(8'h3B);
        push_exp(8'h3B, 8'h01, 8'h9D, 1'b0);
        run_wait(8'h07);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk("hold_done", {Done, Xval, Aval, Bval}, {1'b1, 1'b0, 8'h01, 8'h9D});
        end
        finish_run();

        // Re-run without reload: multiplier is the previous B (-99), A cleared at START.
        push_exp(8'h9D, 8'hFF, 8'h3A, 1'b1);
        run_wait(8'h02);

        // Load while in DONE: B takes S, A/X clear, state stays DONE while Run is high.
        ClearA_LoadB = 1'b1;
        S            = 8'h11;
        @(posedge Clk);
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        chk("done_load", {Done, Xval, Aval, Bval}, {1'b1, 1'b0, 8'h00, 8'h11});
        finish_run();

        // Reset during the 5th SHIFT cycle aborts to the reset state.
        load_b(8'h3B);
        Run = 1'b1;
        S   = 8'h07;
        @(posedge Clk);
        for (int i = 0; i < 10; i++) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        Run   = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        chk("midop_reset", {Done, Xval, Aval, Bval}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        chk("post_reset_idle", {Done, Xval, Aval, Bval, Add_A9}, 32'd0);

        // Run and ClearA_LoadB together in IDLE: load wins, START one cycle later.
        ClearA_LoadB = 1'b1;
        Run          = 1'b1;
        S            = 8'h05;
        @(posedge Clk);
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        chk("both_high_load", {Done, Aval, Bval}, {1'b0, 8'h00, 8'h05});
        push_exp(8'h05, 8'h00, 8'h0F, 1'b0);
        run_wait(8'h03);
        finish_run();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
